rider_ld_monitor: RTL

Datapath companion to the steering-enable state machine. Produces that machine's inputs (tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16) and consumes its clr_tmr output.
- Filters left/right load-cell samples with a 4-deep running average per side.
- Compares the averaged sum and difference against rider-weight thresholds with hysteresis.
- Runs the 1.3 s settle timer.

---
 rtl/rider_ld_monitor.sv | 108 ++++++++++
 1 files changed

// File: rtl/rider_ld_monitor.sv
// Rider load monitor: per-side 4-deep running average, hysteretic weight
// compare, left/right balance compare and the settle timer.
module rider_ld_monitor #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [7:0]  WT_HYSTERESIS = 8'h40,
  parameter bit          FAST_SIM      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        ld_vld,
  input  logic        clr_tmr,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        tmr_full
);

  localparam int TW = FAST_SIM ? 15 : 26;

  localparam logic [12:0] THR_HI =
    {1'b0, MIN_RIDER_WT} + {5'd0, WT_HYSTERESIS};
  localparam logic [12:0] THR_LO =
    {1'b0, MIN_RIDER_WT} - {5'd0, WT_HYSTERESIS};

  logic [11:0]   r_hl [4];
  logic [11:0]   r_hr [4];
  logic [13:0]   r_acc_l;
  logic [13:0]   r_acc_r;
  logic [TW-1:0] r_cnt;
  logic          r_gt;
  logic          r_lt;
  logic          r_d14;
  logic          r_d1516;

  logic [11:0] w_avg_l;
  logic [11:0] w_avg_r;
  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [14:0] w_d4;
  logic [14:0] w_s1;
  logic [16:0] w_d16;
  logic [16:0] w_s15;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_hl[i] <= '0;
        r_hr[i] <= '0;
      end
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (ld_vld) begin
      r_acc_l <= r_acc_l + {2'b00, lft_ld} - {2'b00, r_hl[3]};
      r_acc_r <= r_acc_r + {2'b00, rght_ld} - {2'b00, r_hr[3]};
      r_hl[0] <= lft_ld;
      r_hr[0] <= rght_ld;
      for (int i = 1; i < 4; i++) begin
        r_hl[i] <= r_hl[i-1];
        r_hr[i] <= r_hr[i-1];
      end
    end
  end

  always_comb begin
    w_avg_l = r_acc_l[13:2];
    w_avg_r = r_acc_r[13:2];
    w_sum   = {1'b0, w_avg_l} + {1'b0, w_avg_r};
    w_diff  = (w_avg_l >= w_avg_r) ? (w_avg_l - w_avg_r)
                                   : (w_avg_r - w_avg_l);
    w_d4    = {1'b0, w_diff, 2'b00};
    w_s1    = {2'b00, w_sum};
    w_d16   = {1'b0, w_diff, 4'b0000};
    w_s15   = {4'b0000, w_sum} * 17'd15;
  end

  // Strict compares: equality never sets a flag, and sum==0 forces diff==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gt    <= 1'b0;
      r_lt    <= 1'b1;
      r_d14   <= 1'b0;
      r_d1516 <= 1'b0;
    end else begin
      r_gt    <= (w_sum > THR_HI);
      r_lt    <= (w_sum < THR_LO);
      r_d14   <= (w_d4 > w_s1);
      r_d1516 <= (w_d16 > w_s15);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_tmr) begin
      r_cnt <= '0;
    end else if (!(&r_cnt)) begin
      r_cnt <= r_cnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign sum_gt_min    = r_gt;
  assign sum_lt_min    = r_lt;
  assign diff_gt_1_4   = r_d14;
  assign diff_gt_15_16 = r_d1516;
  assign tmr_full      = &r_cnt;

endmodule
